// File: rtl/button_event_decoder.sv
// Turns debounced button levels into press / release / auto-repeat pulses, one FSM per lane.
// Latency: every output is registered, so events appear 1 cycle after the edge that samples their cause.
// Backpressure: none; pulses are fire-and-forget and the consumer must sample every cycle.
//
// Ports:
//   clk            system clock
//   rst            synchronous, active-low reset
//   btn_level      debounced button levels (1 = pressed), synchronous to clk
//   press_pulse    1-cycle pulse per lane on press
//   release_pulse  1-cycle pulse per lane on release
//   repeat_pulse   1-cycle pulse per lane for each auto-repeat while held
//   held           1 while the lane FSM is not IDLE
module button_event_decoder #(
  parameter int WIDTH         = 4,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000,
  parameter bit REPEAT_EN     = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] btn_level,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse,
  output logic [WIDTH-1:0] repeat_pulse,
  output logic [WIDTH-1:0] held
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  // Terminal counts: the counter runs 0..LAST, so the pulse lands exactly DELAY/PERIOD cycles later.
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  state_t           state      [WIDTH];
  logic [CNT_W-1:0] cnt        [WIDTH];
  logic [WIDTH-1:0] prev_level;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < WIDTH; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
      prev_level    <= '0;
      press_pulse   <= '0;
      release_pulse <= '0;
      repeat_pulse  <= '0;
      held          <= '0;
    end else begin
      prev_level <= btn_level;
      for (int i = 0; i < WIDTH; i++) begin
        press_pulse[i]   <= 1'b0;
        release_pulse[i] <= 1'b0;
        repeat_pulse[i]  <= 1'b0;
        case (state[i])
          IDLE: begin
            // Edge-qualified so a level still high from before a release cannot retrigger.
            if (btn_level[i] && !prev_level[i]) begin
              press_pulse[i] <= 1'b1;
              cnt[i]         <= '0;
              state[i]       <= DELAY;
              held[i]        <= 1'b1;
            end else begin
              held[i] <= 1'b0;
            end
          end
          DELAY: begin
            // Release is checked first so it wins over a coinciding repeat expiry.
            if (!btn_level[i]) begin
              release_pulse[i] <= 1'b1;
              cnt[i]           <= '0;
              state[i]         <= IDLE;
              held[i]          <= 1'b0;
            end else if (REPEAT_EN && cnt[i] == DELAY_LAST) begin
              repeat_pulse[i] <= 1'b1;
              cnt[i]          <= '0;
              state[i]        <= REPEAT;
              held[i]         <= 1'b1;
            end else begin
              // With repeat disabled the counter parks at its terminal value.
              if (cnt[i] != DELAY_LAST) begin
                cnt[i] <= cnt[i] + 1'b1;
              end
              held[i] <= 1'b1;
            end
          end
          REPEAT: begin
            if (!btn_level[i]) begin
              release_pulse[i] <= 1'b1;
              cnt[i]           <= '0;
              state[i]         <= IDLE;
              held[i]          <= 1'b0;
            end else if (cnt[i] == PERIOD_LAST) begin
              repeat_pulse[i] <= 1'b1;
              cnt[i]          <= '0;
              held[i]         <= 1'b1;
            end else begin
              cnt[i]  <= cnt[i] + 1'b1;
              held[i] <= 1'b1;
            end
          end
          default: begin
            state[i] <= IDLE;
            cnt[i]   <= '0;
            held[i]  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with REPEAT_DELAY = 10, REPEAT_PERIOD = 4.
// Inputs change 1 time unit after a rising edge; outputs are checked at the same point.
// Index k counts edges from the press-sampling edge E (k = 0 is the edge that samples the press).
module tb_button_event_decoder;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] btn_level = '0;
  logic [W-1:0] press_pulse;
  logic [W-1:0] release_pulse;
  logic [W-1:0] repeat_pulse;
  logic [W-1:0] held;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  button_event_decoder #(
    .WIDTH        (W),
    .REPEAT_DELAY (10),
    .REPEAT_PERIOD(4),
    .REPEAT_EN    (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .repeat_pulse (repeat_pulse),
    .held         (held)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then check all four outputs.
  task automatic step_chk(input string tag, input logic [W-1:0] p, input logic [W-1:0] r,
                          input logic [W-1:0] rp, input logic [W-1:0] h);
    @(posedge clk);
    #1;
    chk({tag, " press"},   32'(press_pulse),   32'(p));
    chk({tag, " release"}, 32'(release_pulse), 32'(r));
    chk({tag, " repeat"},  32'(repeat_pulse),  32'(rp));
    chk({tag, " held"},    32'(held),          32'(h));
  endtask

  initial begin
    logic [W-1:0] p, r, rp, h;

    // 1. Reset then idle.
    rst = 1'b0;
    btn_level = '0;
    step_chk("t1 rst0", '0, '0, '0, '0);
    step_chk("t1 rst1", '0, '0, '0, '0);
    rst = 1'b1;
    for (int k = 0; k < 20; k++) step_chk($sformatf("t1 idle%0d", k), '0, '0, '0, '0);

    // 2. Lane 0 held 30 cycles; drop sampled at k = 30, which also coincides with a repeat slot.
    btn_level = 4'b0001;
    for (int k = 0; k <= 30; k++) begin
      if (k == 30) btn_level[0] = 1'b0;
      p  = (k == 0) ? 4'b0001 : 4'b0000;
      rp = (k == 10 || k == 14 || k == 18 || k == 22 || k == 26) ? 4'b0001 : 4'b0000;
      r  = (k == 30) ? 4'b0001 : 4'b0000;
      h  = (k < 30) ? 4'b0001 : 4'b0000;
      step_chk($sformatf("t2 k%0d", k), p, r, rp, h);
    end
    step_chk("t2 after", '0, '0, '0, '0);

    // 3. Lane 1 tap of 3 cycles.
    btn_level = 4'b0010;
    for (int k = 0; k <= 3; k++) begin
      if (k == 3) btn_level[1] = 1'b0;
      p = (k == 0) ? 4'b0010 : 4'b0000;
      r = (k == 3) ? 4'b0010 : 4'b0000;
      h = (k < 3) ? 4'b0010 : 4'b0000;
      step_chk($sformatf("t3 k%0d", k), p, r, '0, h);
    end
    step_chk("t3 after", '0, '0, '0, '0);

    // 4. Lane 2 released exactly at its first-repeat edge, then re-pressed the next cycle.
    btn_level = 4'b0100;
    for (int k = 0; k <= 12; k++) begin
      btn_level[2] = (k < 10 || k == 11);
      p = (k == 0 || k == 11) ? 4'b0100 : 4'b0000;
      r = (k == 10 || k == 12) ? 4'b0100 : 4'b0000;
      h = (k < 10 || k == 11) ? 4'b0100 : 4'b0000;
      step_chk($sformatf("t4 k%0d", k), p, r, '0, h);
    end
    step_chk("t4 after", '0, '0, '0, '0);

    // 5. Lanes 0 and 3 pressed together; lane 3 released after 5 cycles, lane 0 after 20.
    btn_level = 4'b1001;
    for (int k = 0; k <= 20; k++) begin
      btn_level[3] = (k < 5);
      btn_level[0] = (k < 20);
      p  = (k == 0) ? 4'b1001 : 4'b0000;
      r  = (k == 5) ? 4'b1000 : ((k == 20) ? 4'b0001 : 4'b0000);
      rp = (k == 10 || k == 14 || k == 18) ? 4'b0001 : 4'b0000;
      h  = {(k < 5), 2'b00, (k < 20)};
      step_chk($sformatf("t5 k%0d", k), p, r, rp, h);
    end
    step_chk("t5 after", '0, '0, '0, '0);

    // 6. Reset while lane 0 is in REPEAT with the button still held; the reset edge
    //    is where the second repeat would have fired.
    btn_level = 4'b0001;
    for (int k = 0; k <= 13; k++) begin
      p  = (k == 0) ? 4'b0001 : 4'b0000;
      rp = (k == 10) ? 4'b0001 : 4'b0000;
      step_chk($sformatf("t6 k%0d", k), p, '0, rp, 4'b0001);
    end
    rst = 1'b0;
    step_chk("t6 rst0", '0, '0, '0, '0);
    step_chk("t6 rst1", '0, '0, '0, '0);
    rst = 1'b1;
    step_chk("t6 repress", 4'b0001, '0, '0, 4'b0001);
    step_chk("t6 hold", '0, '0, '0, 4'b0001);
    btn_level = '0;
    step_chk("t6 release", '0, 4'b0001, '0, '0);
    step_chk("t6 after", '0, '0, '0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
